// File: rtl/cache_fill_controller_pkg.sv
// Shared definitions for the cache fill controller: FSM encoding, block
// geometry defaults and the word-offset shift used to form byte addresses.
package cache_fill_controller_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
  localparam int unsigned DEF_ADDR_W          = 16;
  localparam int unsigned DATA_W              = 16;
  // 16-bit words: word index -> byte offset is a shift by one
  localparam int unsigned WORD_SHIFT          = 1;

endpackage

// File: rtl/cache_fill_controller_fill_word_counter.sv
// Enabled word counter with saturate flag and synchronous clear.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - return to zero (wins over en)
//   en        - advance by one word
//   cnt       - current word index
//   sat       - set once the last index has been counted past
module cache_fill_controller_fill_word_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next count; the index stays on the last word once saturated
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en && !sat_q) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/cache_fill_controller.sv
// Miss handler / memory arbiter for the I- and D-cache. Grants one miss at a
// time (D-cache first), streams the block's words from pipelined memory and
// writes them, plus tag/valid and a done pulse, into the granted cache.
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   icache_miss/_addr, dcache_miss/_addr - held miss requests and addresses
//   mem_data, mem_data_valid        - in-order read data from memory
//   mem_en, mem_addr                - one word read request per cycle
//   fill_wen/_addr/_data, fill_sel  - data-array write into the granted cache
//   tag_wen, fill_done              - last-word tag write and completion pulse
//   busy                            - a fill is in progress
module cache_fill_controller
  import cache_fill_controller_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned ADDR_W          = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_wen,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_sel,
  output logic              tag_wen,
  output logic              fill_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] OFFSET_MASK =
    ~(ADDR_W'((WORDS_PER_BLOCK << WORD_SHIFT) - 1));

  state_e            state_q, state_d;
  logic              fill_sel_q, fill_sel_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              in_fill;
  logic              recv_last;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              issue_sat, recv_sat;
  logic              cnt_clr;

  assign in_fill   = (state_q == ST_FILL);
  assign recv_last = in_fill && mem_data_valid &&
                     (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  // Both sides restart from word 0 for every fill
  assign cnt_clr   = !in_fill || recv_last;

  cache_fill_controller_fill_word_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (in_fill && !issue_sat),
    .cnt (issue_cnt),
    .sat (issue_sat)
  );

  cache_fill_controller_fill_word_counter #(.CNT_W(CNT_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (in_fill && mem_data_valid),
    .cnt (recv_cnt),
    .sat (recv_sat)
  );

  // Grant (fixed D-cache priority) and fill completion
  always_comb begin
    state_d    = state_q;
    fill_sel_d = fill_sel_q;
    base_d     = base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dcache_miss) begin
          fill_sel_d = 1'b1;
          base_d     = dcache_miss_addr & OFFSET_MASK;
          state_d    = ST_FILL;
        end else if (icache_miss) begin
          fill_sel_d = 1'b0;
          base_d     = icache_miss_addr & OFFSET_MASK;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        // recv_sat cannot be reached normally; it guards against a lost exit
        if (recv_last || recv_sat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fill_sel_q <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_sel_q <= fill_sel_d;
      base_q     <= base_d;
    end
  end

  // Memory request side and cache write side; address/data forced to 0 when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    fill_wen  = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    tag_wen   = 1'b0;
    fill_done = 1'b0;
    if (in_fill && !issue_sat) begin
      mem_en   = 1'b1;
      mem_addr = base_q | (ADDR_W'(issue_cnt) << WORD_SHIFT);
    end
    if (in_fill && mem_data_valid) begin
      fill_wen  = 1'b1;
      fill_addr = base_q | (ADDR_W'(recv_cnt) << WORD_SHIFT);
      fill_data = mem_data;
    end
    tag_wen   = recv_last;
    fill_done = recv_last;
  end

  assign fill_sel = fill_sel_q;
  assign busy     = in_fill;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller with a pipelined memory model of
// selectable latency and per-cycle logs of issues, writes and completions.
module tb_cache_fill_controller;

  logic        clk;
  logic        rst;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        fill_wen;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        fill_sel;
  logic        tag_wen;
  logic        fill_done;
  logic        busy;

  cache_fill_controller dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .mem_data         (mem_data),
    .mem_data_valid   (mem_data_valid),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .fill_wen         (fill_wen),
    .fill_addr        (fill_addr),
    .fill_data        (fill_data),
    .fill_sel         (fill_sel),
    .tag_wen          (tag_wen),
    .fill_done        (fill_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 4;
  int idx;
  logic        stray_v = 1'b0;
  logic [15:0] stray_d = 16'h0;

  logic        sched_v [0:31];
  logic [15:0] sched_a [0:31];

  int          iss_cyc  [0:127];
  logic [15:0] iss_addr [0:127];
  int          n_iss = 0;
  int          wr_cyc   [0:127];
  logic [15:0] wr_addr  [0:127];
  logic [15:0] wr_data  [0:127];
  logic        wr_sel   [0:127];
  int          n_wr = 0;
  int          done_cyc [0:15];
  int          n_done = 0;
  int          n_tag = 0;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model (request in cycle c -> data in cycle c+lat) plus output logging
  initial begin
    for (int i = 0; i < 32; i++) begin
      sched_v[i] = 1'b0;
      sched_a[i] = 16'h0;
    end
    mem_data_valid = 1'b0;
    mem_data       = 16'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #3;
      idx = cyc % 32;
      if (!rst) begin
        for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0;
      end else if (stray_v) begin
        mem_data_valid = 1'b1;
        mem_data       = stray_d;
      end else if (sched_v[idx]) begin
        mem_data_valid = 1'b1;
        mem_data       = mdata(sched_a[idx]);
        sched_v[idx]   = 1'b0;
      end else begin
        mem_data_valid = 1'b0;
        mem_data       = 16'h0;
      end
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
      end else begin
        if (mem_en) begin
          sched_v[(cyc + lat) % 32] = 1'b1;
          sched_a[(cyc + lat) % 32] = mem_addr;
          if (n_iss < 128) begin
            iss_cyc[n_iss]  = cyc;
            iss_addr[n_iss] = mem_addr;
            n_iss++;
          end
        end
        if (fill_wen && n_wr < 128) begin
          wr_cyc[n_wr]  = cyc;
          wr_addr[n_wr] = fill_addr;
          wr_data[n_wr] = fill_data;
          wr_sel[n_wr]  = fill_sel;
          n_wr++;
        end
        if (fill_done && n_done < 16) begin
          done_cyc[n_done] = cyc;
          n_done++;
        end
        if (tag_wen) n_tag++;
      end
    end
  end

  // Eight issues and eight writes of one block, from log positions i0/w0
  task automatic check_fill(input string tag, input int i0, input int w0,
                            input logic [15:0] base, input logic sel,
                            input int t_iss, input int t_wr);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      check_eq($sformatf("%s iss%0d addr", tag, k), 32'(iss_addr[i0 + k]), 32'(a));
      check_eq($sformatf("%s iss%0d cyc", tag, k), 32'(iss_cyc[i0 + k]), 32'(t_iss + k));
      check_eq($sformatf("%s wr%0d addr", tag, k), 32'(wr_addr[w0 + k]), 32'(a));
      check_eq($sformatf("%s wr%0d cyc", tag, k), 32'(wr_cyc[w0 + k]), 32'(t_wr + k));
      check_eq($sformatf("%s wr%0d data", tag, k), 32'(wr_data[w0 + k]), 32'(mdata(a)));
      check_eq($sformatf("%s wr%0d sel", tag, k), 32'(wr_sel[w0 + k]), 32'(sel));
    end
  endtask

  task automatic check_counts(input string tag, input int i0, input int w0,
                              input int d0, input int g0, input int nblk);
    check_eq({tag, " n_iss"},  32'(n_iss - i0),  32'(8 * nblk));
    check_eq({tag, " n_wr"},   32'(n_wr - w0),   32'(8 * nblk));
    check_eq({tag, " n_done"}, 32'(n_done - d0), 32'(nblk));
    check_eq({tag, " n_tag"},  32'(n_tag - g0),  32'(nblk));
  endtask

  int t, i0, w0, d0, g0;

  initial begin
    rst = 1'b1;
    icache_miss = 1'b0; icache_miss_addr = 16'h0;
    dcache_miss = 1'b0; dcache_miss_addr = 16'h0;
    #1 rst = 1'b0;
    #1;
    check_eq("rst mem_en",    32'(mem_en),    32'd0);
    check_eq("rst mem_addr",  32'(mem_addr),  32'd0);
    check_eq("rst fill_wen",  32'(fill_wen),  32'd0);
    check_eq("rst fill_addr", 32'(fill_addr), 32'd0);
    check_eq("rst fill_data", 32'(fill_data), 32'd0);
    check_eq("rst fill_sel",  32'(fill_sel),  32'd0);
    check_eq("rst tag_wen",   32'(tag_wen),   32'd0);
    check_eq("rst fill_done", 32'(fill_done), 32'd0);
    check_eq("rst busy",      32'(busy),      32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // I-miss alone, latency 4
    lat = 4;
    step();
    t = cyc; i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    icache_miss_addr = 16'h1234; icache_miss = 1'b1;
    check_eq("t1 busy idle", 32'(busy), 32'd0);
    step();
    check_eq("t1 busy fill", 32'(busy), 32'd1);
    check_eq("t1 mem_en", 32'(mem_en), 32'd1);
    check_eq("t1 mem_addr", 32'(mem_addr), 32'h1230);
    check_eq("t1 fill_sel", 32'(fill_sel), 32'd0);
    repeat (11) step();
    icache_miss = 1'b0;
    step();
    check_eq("t1 idle after", 32'(busy), 32'd0);
    step();
    check_eq("t1 stays idle", 32'(busy), 32'd0);
    check_fill("t1", i0, w0, 16'h1230, 1'b0, t + 1, t + 5);
    check_counts("t1", i0, w0, d0, g0, 1);
    check_eq("t1 done cyc", 32'(done_cyc[d0]), 32'(t + 12));

    // Simultaneous I and D misses: D first, one idle cycle, then I
    step();
    t = cyc; i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    icache_miss_addr = 16'h0040; icache_miss = 1'b1;
    dcache_miss_addr = 16'h8F06; dcache_miss = 1'b1;
    step();
    check_eq("t2 d sel", 32'(fill_sel), 32'd1);
    repeat (11) step();
    dcache_miss = 1'b0;
    step();
    check_eq("t2 gap idle", 32'(busy), 32'd0);
    step();
    check_eq("t2 i busy", 32'(busy), 32'd1);
    check_eq("t2 i sel", 32'(fill_sel), 32'd0);
    repeat (11) step();
    icache_miss = 1'b0;
    repeat (2) step();
    check_fill("t2d", i0, w0, 16'h8F00, 1'b1, t + 1, t + 5);
    check_fill("t2i", i0 + 8, w0 + 8, 16'h0040, 1'b0, t + 14, t + 18);
    check_counts("t2", i0, w0, d0, g0, 2);
    check_eq("t2 d done cyc", 32'(done_cyc[d0]), 32'(t + 12));
    check_eq("t2 i done cyc", 32'(done_cyc[d0 + 1]), 32'(t + 25));

    // Latency 1: receive overlaps issue
    lat = 1;
    step();
    t = cyc; i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    dcache_miss_addr = 16'h3456; dcache_miss = 1'b1;
    repeat (9) step();
    dcache_miss = 1'b0;
    repeat (2) step();
    check_fill("t3", i0, w0, 16'h3450, 1'b1, t + 1, t + 2);
    check_counts("t3", i0, w0, d0, g0, 1);
    check_eq("t3 done cyc", 32'(done_cyc[d0]), 32'(t + 9));

    // Stray valid while idle is ignored, next fill starts at word 0
    lat = 4;
    step();
    w0 = n_wr;
    stray_d = 16'hDEAD; stray_v = 1'b1;
    #3;
    check_eq("t4 stray fill_wen", 32'(fill_wen), 32'd0);
    check_eq("t4 stray fill_addr", 32'(fill_addr), 32'd0);
    check_eq("t4 stray fill_data", 32'(fill_data), 32'd0);
    check_eq("t4 stray fill_done", 32'(fill_done), 32'd0);
    check_eq("t4 stray busy", 32'(busy), 32'd0);
    step();
    stray_v = 1'b0;
    check_eq("t4 stray no write", 32'(n_wr - w0), 32'd0);
    t = cyc; i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    icache_miss_addr = 16'h0100; icache_miss = 1'b1;
    repeat (12) step();
    icache_miss = 1'b0;
    repeat (2) step();
    check_fill("t4", i0, w0, 16'h0100, 1'b0, t + 1, t + 5);
    check_counts("t4", i0, w0, d0, g0, 1);
    check_eq("t4 done cyc", 32'(done_cyc[d0]), 32'(t + 12));

    // Reset at t+6 of a D fill; miss still pending refills from word 0
    step();
    t = cyc;
    dcache_miss_addr = 16'h2000; dcache_miss = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    #1;
    check_eq("t5 rst mem_en", 32'(mem_en), 32'd0);
    check_eq("t5 rst mem_addr", 32'(mem_addr), 32'd0);
    check_eq("t5 rst fill_wen", 32'(fill_wen), 32'd0);
    check_eq("t5 rst fill_addr", 32'(fill_addr), 32'd0);
    check_eq("t5 rst fill_sel", 32'(fill_sel), 32'd0);
    check_eq("t5 rst tag_wen", 32'(tag_wen), 32'd0);
    check_eq("t5 rst fill_done", 32'(fill_done), 32'd0);
    check_eq("t5 rst busy", 32'(busy), 32'd0);
    i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    step();
    rst = 1'b1;
    step();
    check_eq("t5 refill busy", 32'(busy), 32'd1);
    check_eq("t5 refill addr", 32'(mem_addr), 32'h2000);
    repeat (11) step();
    dcache_miss = 1'b0;
    repeat (2) step();
    check_fill("t5", i0, w0, 16'h2000, 1'b1, t + 8, t + 12);
    check_counts("t5", i0, w0, d0, g0, 1);
    check_eq("t5 done cyc", 32'(done_cyc[d0]), 32'(t + 19));

    // Miss line dropped at t+3: fill still completes
    step();
    t = cyc; i0 = n_iss; w0 = n_wr; d0 = n_done; g0 = n_tag;
    icache_miss_addr = 16'h0F2A; icache_miss = 1'b1;
    repeat (3) step();
    icache_miss = 1'b0;
    check_eq("t6 busy after drop", 32'(busy), 32'd1);
    repeat (11) step();
    check_eq("t6 idle at end", 32'(busy), 32'd0);
    check_fill("t6", i0, w0, 16'h0F20, 1'b0, t + 1, t + 5);
    check_counts("t6", i0, w0, d0, g0, 1);
    check_eq("t6 done cyc", 32'(done_cyc[d0]), 32'(t + 12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
